// File: rtl/pipeline_stage_reg_if.sv
// Interface bundling the stage-to-stage signals of pipeline_stage_reg.
// master: the side that drives stalls, flush and the incoming payload.
// slave : the pipeline register itself.
//
// Handshake: out_valid qualifies out. There is no ready signal.
// The consuming stage applies backpressure through stall_next_stage_in.
// A held payload keeps out/out_valid stable until the stall clears or a flush discards it.
interface pipeline_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             stall_current_stage_in;
    logic             stall_next_stage_in;
    logic             flush_in;
    logic             in_valid;
    logic [WIDTH-1:0] in;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic [1:0]       stage_state;
    logic [31:0]      bubble_count;

    modport master (
        output stall_current_stage_in,
        output stall_next_stage_in,
        output flush_in,
        output in_valid,
        output in,
        input  out_valid,
        input  out,
        input  stage_state,
        input  bubble_count
    );

    modport slave (
        input  stall_current_stage_in,
        input  stall_next_stage_in,
        input  flush_in,
        input  in_valid,
        input  in,
        output out_valid,
        output out,
        output stage_state,
        output bubble_count
    );
endinterface

// File: rtl/pipeline_stage_reg.sv
// Registered pipeline-stage latch with valid tracking.
// Each edge it passes, holds, bubbles or flushes the payload, based on stretched stall inputs
// and a flush request. stage_state reports the action taken at the last edge.
// Optional feature macro: PIPE_BUBBLE_COUNT_EN enables a saturating 32-bit bubble counter.
// Without it, bubble_count is tied to zero.
module pipeline_stage_reg #(
    parameter int               WIDTH        = 32,
    parameter int               STALL_EXTEND = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stage_reg_if.slave  pipe
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HOLD   = 2'b01,
        ST_BUBBLE = 2'b10,
        ST_FLUSH  = 2'b11
    } state_t;

    localparam logic [3:0] EXT_LOAD = 4'(STALL_EXTEND);

    logic [3:0]       r_ext_c;
    logic [3:0]       r_ext_n;
    logic             w_sc;
    logic             w_sn;
    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_next_out;
    logic             r_out_valid;
    logic             w_next_valid;

    // A stall is effective while raw or while its stretch counter is still running.
    assign w_sc = pipe.stall_current_stage_in | (r_ext_c != 4'd0);
    assign w_sn = pipe.stall_next_stage_in    | (r_ext_n != 4'd0);

    // Stretch counters: a raw stall reloads them (no accumulation), then they count down.
    // A flush clears them, even when a raw stall is present in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || pipe.flush_in) begin
            r_ext_c <= 4'd0;
            r_ext_n <= 4'd0;
        end else begin
            if (pipe.stall_current_stage_in) begin
                r_ext_c <= EXT_LOAD;
            end else if (r_ext_c != 4'd0) begin
                r_ext_c <= r_ext_c - 4'd1;
            end
            if (pipe.stall_next_stage_in) begin
                r_ext_n <= EXT_LOAD;
            end else if (r_ext_n != 4'd0) begin
                r_ext_n <= r_ext_n - 4'd1;
            end
        end
    end

    // Action select in priority order: flush, bubble, run, hold.
    always_comb begin
        w_next_state = ST_HOLD;
        w_next_out   = r_out;
        w_next_valid = r_out_valid;
        if (pipe.flush_in) begin
            w_next_state = ST_FLUSH;
            w_next_out   = BUBBLE_VALUE;
            w_next_valid = 1'b0;
        end else if (w_sc && !w_sn) begin
            w_next_state = ST_BUBBLE;
            w_next_out   = BUBBLE_VALUE;
            w_next_valid = 1'b0;
        end else if (!w_sc && !w_sn) begin
            w_next_state = ST_RUN;
            w_next_out   = pipe.in;
            w_next_valid = pipe.in_valid;
        end
    end

    // Stage register: payload, valid and last action all update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_out       <= BUBBLE_VALUE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out       <= w_next_out;
            r_out_valid <= w_next_valid;
        end
    end

`ifdef PIPE_BUBBLE_COUNT_EN
    logic [31:0] r_bubble_count;

    // Bubble counter: one per BUBBLE action, saturates, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_count <= 32'd0;
        end else if ((w_next_state == ST_BUBBLE) && (r_bubble_count != 32'hFFFF_FFFF)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign pipe.bubble_count = r_bubble_count;
`else
    assign pipe.bubble_count = 32'd0;
`endif

    assign pipe.out         = r_out;
    assign pipe.out_valid   = r_out_valid;
    assign pipe.stage_state = r_state;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Testbench for pipeline_stage_reg.
// The driver applies directed and random stimulus on the falling edge.
// For each edge it pushes the expected outputs of a reference model into exp_q.
// The monitor pops one entry after every rising edge and compares it with the DUT.
module tb_pipeline_stage_reg;

    localparam int          WIDTH = 32;
    localparam int          SE    = 1;
    localparam logic [31:0] BV    = 32'd0;
    localparam int          EW    = WIDTH + 1 + 2 + 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_stage_reg_if #(.WIDTH(WIDTH)) ifc ();

    pipeline_stage_reg #(
        .WIDTH        (WIDTH),
        .STALL_EXTEND (SE),
        .BUBBLE_VALUE (BV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (ifc.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;

    // ---------------- reference model ----------------
    // Stall stretch: a stall is effective if raw now, or if its last raw assertion was
    // at most SE edges ago. Flush and reset forget past assertions.
    logic [WIDTH-1:0] m_out;
    logic             m_valid;
    logic [1:0]       m_state;
    logic [31:0]      m_count;
    int               cyc;
    int               last_c;
    int               last_n;
    bit               has_c;
    bit               has_n;

    task automatic model_step(input bit r, input bit sc_raw, input bit sn_raw, input bit fl,
                              input bit v, input logic [WIDTH-1:0] d);
        bit sc;
        bit sn;
        if (r) begin
            m_out   = BV;
            m_valid = 1'b0;
            m_state = 2'b00;
            m_count = 32'd0;
            has_c   = 1'b0;
            has_n   = 1'b0;
        end else begin
            sc = sc_raw || (has_c && ((cyc - last_c) <= SE));
            sn = sn_raw || (has_n && ((cyc - last_n) <= SE));
            if (fl) begin
                m_out   = BV;
                m_valid = 1'b0;
                m_state = 2'b11;
                has_c   = 1'b0;
                has_n   = 1'b0;
            end else begin
                if (sc_raw) begin
                    has_c  = 1'b1;
                    last_c = cyc;
                end
                if (sn_raw) begin
                    has_n  = 1'b1;
                    last_n = cyc;
                end
                if (sc && !sn) begin
                    m_out   = BV;
                    m_valid = 1'b0;
                    m_state = 2'b10;
`ifdef PIPE_BUBBLE_COUNT_EN
                    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
`endif
                end else if (!sc && !sn) begin
                    m_out   = d;
                    m_valid = v;
                    m_state = 2'b00;
                end else begin
                    m_state = 2'b01;
                end
            end
        end
        cyc = cyc + 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_now(input bit r, input bit sc, input bit sn, input bit fl,
                             input bit v, input logic [WIDTH-1:0] d);
        rst                        = r;
        ifc.stall_current_stage_in = sc;
        ifc.stall_next_stage_in    = sn;
        ifc.flush_in               = fl;
        ifc.in_valid               = v;
        ifc.in                     = d;
        model_step(r, sc, sn, fl, v, d);
        exp_q.push_back({m_out, m_valid, m_state, m_count});
    endtask

    task automatic step(input bit r, input bit sc, input bit sn, input bit fl,
                        input bit v, input logic [WIDTH-1:0] d);
        @(negedge clk);
        drive_now(r, sc, sn, fl, v, d);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out",          64'(ifc.out),          64'(e[EW-1 -: WIDTH]));
                check("out_valid",    64'(ifc.out_valid),    64'(e[34]));
                check("stage_state",  64'(ifc.stage_state),  64'(e[33:32]));
                check("bubble_count", 64'(ifc.bubble_count), 64'(e[31:0]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last_c   = 0;
        last_n   = 0;
        has_c    = 1'b0;
        has_n    = 1'b0;
        m_out    = BV;
        m_valid  = 1'b0;
        m_state  = 2'b00;
        m_count  = 32'd0;
        rst                        = 1'b1;
        ifc.stall_current_stage_in = 1'b0;
        ifc.stall_next_stage_in    = 1'b0;
        ifc.flush_in               = 1'b0;
        ifc.in_valid               = 1'b0;
        ifc.in                     = '0;

        // Reset with garbage on the input.
        step(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        step(1, 0, 0, 0, 1, 32'hDEAD_BEEF);

        // Pass-through.
        step(0, 0, 0, 0, 1, 32'd1);
        step(0, 0, 0, 0, 1, 32'd2);
        step(0, 0, 0, 0, 1, 32'd3);

        // Hold: capture 5, then stall the consumer for 3 cycles while in changes.
        // The stretch keeps it held one more cycle, then in passes again.
        step(0, 0, 0, 0, 1, 32'd5);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 32'd100 + 32'(i));
        step(0, 0, 0, 0, 1, 32'd200);
        step(0, 0, 0, 0, 1, 32'd201);

        // Bubble from a fresh reset: one raw cycle gives two bubbles.
        step(1, 0, 0, 0, 0, 32'd0);
        step(0, 1, 0, 0, 1, 32'd11);
        step(0, 0, 0, 0, 1, 32'd12);
        step(0, 0, 0, 0, 1, 32'd13);
        step(0, 0, 0, 0, 1, 32'd14);

        // Flush priority over a stall while 7 is held, then a free cycle passes in.
        step(0, 0, 0, 0, 1, 32'd7);
        step(0, 0, 1, 0, 1, 32'd8);
        step(0, 1, 1, 1, 1, 32'd9);
        step(0, 0, 0, 0, 1, 32'd10);
        step(0, 0, 0, 0, 1, 32'd15);

        // Re-stall while stretch is still running: reload, no accumulation.
        step(0, 1, 0, 0, 1, 32'd20);
        step(0, 1, 0, 0, 1, 32'd21);
        step(0, 0, 0, 0, 1, 32'd22);
        step(0, 0, 0, 0, 1, 32'd23);

        // Reset mid-hold: stretch does not survive.
        step(0, 0, 1, 0, 1, 32'd30);
        step(1, 0, 0, 0, 1, 32'd31);
        step(0, 0, 0, 0, 1, 32'd32);

`ifdef PIPE_BUBBLE_COUNT_EN
        // Saturation: preload near the top, then three bubble cycles.
        @(negedge clk);
        force dut.r_bubble_count = 32'hFFFF_FFFE;
        m_count = 32'hFFFF_FFFE;
        drive_now(0, 1, 0, 0, 1, 32'd40);
        #1;
        release dut.r_bubble_count;
        step(0, 1, 0, 0, 1, 32'd41);
        step(0, 1, 0, 0, 1, 32'd42);
        step(0, 0, 0, 0, 1, 32'd43);
        step(0, 0, 0, 0, 1, 32'd44);
`endif

        // Randomized stimulus.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)),
                 WIDTH'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
